div_sequencer: RTL and testbench

//   Multi-cycle integer divider controller. Accepts one N/D operand pair on a

---
 rtl/div_sequencer.sv | 132 +++++++++++++
 tb/tb_div_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider controller, one quotient bit per clock.
// Optional signed mode: define DIV_SIGNED_EN (adds sign capture and FIX state).
module div_sequencer #(
  parameter int INPUT_SIZE = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INPUT_SIZE-1:0] N,
  input  logic [INPUT_SIZE-1:0] D,
  output logic                  busy,
  output logic                  done,
  output logic [INPUT_SIZE-1:0] Q,
  output logic [INPUT_SIZE-1:0] R,
  output logic                  divByZero
);

  localparam int W  = INPUT_SIZE;
  localparam int CW = $clog2(INPUT_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  nShift;
  logic [W-1:0]  dReg;
  logic [CW-1:0] iCnt;
  logic [W-1:0]  trial;
  logic          qBit;
  logic [W-1:0]  nCap;
  logic [W-1:0]  dCap;

`ifdef DIV_SIGNED_EN
  logic signN;
  logic signD;

  // The datapath always works on magnitudes; signs are reapplied in FIX.
  assign nCap = N[W-1] ? -N : N;
  assign dCap = D[W-1] ? -D : D;
`else
  assign nCap = N;
  assign dCap = D;
`endif

  always_comb begin
    trial = {R[W-2:0], nShift[W-1]};
    qBit  = (trial >= dReg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      Q         <= '0;
      R         <= '0;
      divByZero <= 1'b0;
      nShift    <= '0;
      dReg      <= '0;
      iCnt      <= '0;
`ifdef DIV_SIGNED_EN
      signN     <= 1'b0;
      signD     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            nShift <= nCap;
            dReg   <= dCap;
            iCnt   <= CW'(W);
            busy   <= 1'b1;
`ifdef DIV_SIGNED_EN
            signN  <= N[W-1];
            signD  <= D[W-1];
`endif
            if (D == '0) begin
              Q         <= '1;
              R         <= N;
              divByZero <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              Q         <= '0;
              R         <= '0;
              divByZero <= 1'b0;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          nShift <= nShift << 1;
          R      <= qBit ? trial - dReg : trial;
          Q      <= {Q[W-2:0], qBit};
          iCnt   <= iCnt - CW'(1);
          if (iCnt == CW'(1)) begin
`ifdef DIV_SIGNED_EN
            state <= FIX;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          if (signN ^ signD) Q <= -Q;
          if (signN) R <= -R;
`endif
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_div_sequencer;

  localparam int W = 10;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] N;
  logic [W-1:0] D;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         divByZero;

  int errors = 0;
  int checks = 0;

  div_sequencer #(.INPUT_SIZE(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .N(N),
    .D(D),
    .busy(busy),
    .done(done),
    .Q(Q),
    .R(R),
    .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    int sn;
    int sd;
    if (d == '0) begin
      q  = '1;
      r  = n;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
`ifdef DIV_SIGNED_EN
      sn = int'($signed(n));
      sd = int'($signed(d));
`else
      sn = int'(n);
      sd = int'(d);
`endif
      q = W'(sn / sd);
      r = W'(sn % sd);
    end
  endfunction

  // Starts a divide; optionally pulses a competing start at cycle ignoreAt.
  task automatic runDiv(input logic [W-1:0] n, input logic [W-1:0] d,
                        input int ignoreAt, output int lat,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int busyBad);
    @(negedge clk);
    start = 1'b1;
    N = n;
    D = d;
    lat = -1;
    busyBad = 0;
    q = '0;
    r = '0;
    dz = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == ignoreAt) begin
        start = 1'b1;
        N = 10'd9;
        D = 10'd2;
      end else begin
        start = 1'b0;
        N = W'($urandom);
        D = W'($urandom);
      end
      if (!busy) busyBad++;
      if (done) begin
        lat = c;
        q = Q;
        r = R;
        dz = divByZero;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    N = '0;
    D = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Q !== '0 || R !== '0 || divByZero !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b Q=%0d R=%0d dz=%b, want all zero",
               busy, done, Q, R, divByZero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    int bb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    runDiv(10'd100, 10'd7, 0, lat, q, r, dz, bb);
    checks++;
    if (lat !== LAT || q !== 10'd14 || r !== 10'd2 || dz !== 1'b0) begin
      errors++;
      $display("FAIL basic_100_7: lat=%0d Q=%0d R=%0d dz=%b, want lat=%0d Q=14 R=2 dz=0",
               lat, q, r, dz, LAT);
    end
    checks++;
    if (bb !== 0) begin
      errors++;
      $display("FAIL basic_busy: busy low in %0d run cycles, want 0", bb);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Q !== 10'd14 || R !== 10'd2) begin
      errors++;
      $display("FAIL basic_after: busy=%b done=%b Q=%0d R=%0d, want 0 0 14 2",
               busy, done, Q, R);
    end
  endtask

  task automatic test_edges;
    int lat;
    int bb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    runDiv(10'd1023, 10'd1, 0, lat, q, r, dz, bb);
    checks++;
    if (lat !== LAT || q !== 10'd1023 || r !== 10'd0) begin
      errors++;
      $display("FAIL edge_1023_1: lat=%0d Q=%0d R=%0d, want lat=%0d Q=1023 R=0",
               lat, q, r, LAT);
    end
    runDiv(10'd3, 10'd1000, 0, lat, q, r, dz, bb);
    checks++;
    if (lat !== LAT || q !== 10'd0 || r !== 10'd3) begin
      errors++;
      $display("FAIL edge_3_1000: lat=%0d Q=%0d R=%0d, want lat=%0d Q=0 R=3",
               lat, q, r, LAT);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    int bb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    runDiv(10'd5, 10'd0, 0, lat, q, r, dz, bb);
    checks++;
    if (lat !== 1 || q !== 10'd1023 || r !== 10'd5 || dz !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: lat=%0d Q=%0d R=%0d dz=%b, want lat=1 Q=1023 R=5 dz=1",
               lat, q, r, dz);
    end
    runDiv(10'd100, 10'd7, 0, lat, q, r, dz, bb);
    checks++;
    if (dz !== 1'b0 || q !== 10'd14) begin
      errors++;
      $display("FAIL div_zero_clear: dz=%b Q=%0d, want dz=0 Q=14", dz, q);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    int bb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    runDiv(10'd100, 10'd7, 4, lat, q, r, dz, bb);
    checks++;
    if (lat !== LAT || q !== 10'd14 || r !== 10'd2) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d Q=%0d R=%0d, want lat=%0d Q=14 R=2",
               lat, q, r, LAT);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_not_queued: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int bb;
    int dones;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    @(negedge clk);
    start = 1'b1;
    N = 10'd100;
    D = 10'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Q !== '0 || R !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b Q=%0d R=%0d, want 0 0 0 0",
               busy, done, Q, R);
    end
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d active cycles after reset, want 0", dones);
    end
    runDiv(10'd200, 10'd9, 0, lat, q, r, dz, bb);
    checks++;
    if (lat !== LAT || q !== 10'd22 || r !== 10'd2) begin
      errors++;
      $display("FAIL reset_mid_next: lat=%0d Q=%0d R=%0d, want lat=%0d Q=22 R=2",
               lat, q, r, LAT);
    end
  endtask

  task automatic test_random;
    int lat;
    int bb;
    int expLat;
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic edz;
    for (int k = 0; k < 40; k++) begin
      n = W'($urandom);
      d = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 1023));
      if (k == 0) d = '0;
      model(n, d, eq, er, edz);
      expLat = edz ? 1 : LAT;
      runDiv(n, d, 0, lat, q, r, dz, bb);
      checks++;
      if (lat !== expLat || q !== eq || r !== er || dz !== edz || bb !== 0) begin
        errors++;
        $display("FAIL random_%0d: N=%0d D=%0d got lat=%0d Q=%0d R=%0d dz=%b bb=%0d, want lat=%0d Q=%0d R=%0d dz=%b",
                 k, n, d, lat, q, r, dz, bb, expLat, eq, er, edz);
      end
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    int lat;
    int bb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    runDiv(W'(-100), 10'd7, 0, lat, q, r, dz, bb);
    checks++;
    if (lat !== W + 2 || q !== W'(-14) || r !== W'(-2)) begin
      errors++;
      $display("FAIL signed_n100_7: lat=%0d Q=%0d R=%0d, want lat=%0d Q=%0d R=%0d",
               lat, q, r, W + 2, W'(-14), W'(-2));
    end
    runDiv(10'd100, W'(-7), 0, lat, q, r, dz, bb);
    checks++;
    if (q !== W'(-14) || r !== 10'd2) begin
      errors++;
      $display("FAIL signed_100_n7: Q=%0d R=%0d, want Q=%0d R=2", q, r, W'(-14));
    end
    runDiv(10'h200, W'(-1), 0, lat, q, r, dz, bb);
    checks++;
    if (q !== 10'h200 || r !== 10'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL signed_wrap: Q=%0d R=%0d dz=%b, want Q=512 R=0 dz=0", q, r, dz);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
